// File: rtl/memory_responder.sv
// Word-addressed 16-bit memory model with a fixed-latency, fully pipelined read return path.
// Define MEM_ALIGN_CHECK_EN to build the misaligned-access flag; otherwise memory_addr_err is tied low.
module memory_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_read_en,
    input  logic        memory_write_en,
    input  logic [15:0] memory_address,
    input  logic [15:0] memory_data_in,
    output logic [15:0] memory_data_out,
    output logic        memory_data_valid,
    output logic        memory_addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  rd_fire;
    logic                  wr_fire;

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    valid_d;
    logic [15:0]           data_q [LATENCY];
    logic [15:0]           data_d [LATENCY];

    // Byte bit 0 and any bits above the array size do not select data.
    logic [15:0]           unused_addr;
    assign unused_addr = memory_address;

    assign word_idx = memory_address[DEPTH_LOG2:1];

    // A simultaneous write wins and the read is dropped; reset blocks both.
    always_comb begin
        rd_fire = memory_read_en & ~memory_write_en & ~rst;
        wr_fire = memory_write_en & ~rst;
    end

    always_comb begin
        valid_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = '0;
        end
        valid_d[0] = rd_fire;
        data_d[0]  = rd_fire ? mem_q[word_idx] : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Array storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[word_idx] <= memory_data_in;
        end
    end

    assign memory_data_valid = valid_q[LATENCY-1];
    assign memory_data_out   = data_q[LATENCY-1];

`ifdef MEM_ALIGN_CHECK_EN
    logic [LATENCY-1:0] err_q;
    logic [LATENCY-1:0] err_d;
    logic               wr_err_q;
    logic               wr_err_d;

    // Read errors travel with their beat; write errors report one cycle after the write.
    always_comb begin
        err_d    = '0;
        err_d[0] = rd_fire & memory_address[0];
        for (int i = 1; i < LATENCY; i++) begin
            err_d[i] = err_q[i-1];
        end
        wr_err_d = wr_fire & memory_address[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign memory_addr_err = err_q[LATENCY-1] | wr_err_q;
`else
    assign memory_addr_err = 1'b0;
`endif

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the cycles from read request to data return (legal range 1..8).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 15, meaning log2 of the number of 16-bit words in the array.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port memory_read_en, input, 1 bit: issues a read request this cycle.
REQ-006 The block SHALL have port memory_write_en, input, 1 bit: issues a write request this cycle.
REQ-007 The block SHALL have port memory_address, input, 16 bits: byte address of the request.
REQ-008 The block SHALL have port memory_data_in, input, 16 bits: write data from the cache.
REQ-009 The block SHALL have port memory_data_out, output, 16 bits: read-return data.
REQ-010 The block SHALL have port memory_data_valid, output, 1 bit: memory_data_out carries a returned read this cycle.
REQ-011 The block SHALL have port memory_addr_err, output, 1 bit: misaligned-access flag (see Configuration).

Function
REQ-012 Word index SHALL be memory_address[DEPTH_LOG2:1]; address bits above DEPTH_LOG2 ignored; bit 0 ignored for data selection.
REQ-013 A write SHALL update the array at the rising edge of the cycle in which memory_write_en=1; no response generated.
REQ-014 A read SHALL sample the array in its issue cycle, carry the word through a LATENCY-deep valid/data shift pipeline, and assert memory_data_valid exactly LATENCY cycles after issue.
REQ-015 Reads SHALL be fully pipelined: one new read accepted every cycle, up to LATENCY in flight, responses returned in issue order.
REQ-016 With memory_read_en=1 on 8 consecutive cycles at block addresses A..A+14 step 2, the block SHALL return 8 consecutive valid beats with matching words.
REQ-017 When memory_read_en and memory_write_en are both 1, the write SHALL be performed and the read dropped (no valid beat generated).
REQ-018 A read issued in cycle N+1 or later SHALL observe a write performed in cycle N to the same word; a read issued in the same cycle as a write cannot occur (REQ-017).
REQ-019 memory_data_out SHALL be 16'h0000 whenever memory_data_valid=0.
REQ-020 Address wrap: index arithmetic SHALL be truncating; address 16'hFFFE maps to the top word with DEPTH_LOG2=15.
REQ-021 The block SHALL have no backpressure; the requester must accept every valid beat.

Reset
REQ-022 While rst=1: all pipeline valid bits SHALL clear, memory_data_valid=0, memory_data_out=0, memory_addr_err=0, and requests SHALL be ignored.
REQ-023 Reset mid-operation SHALL discard all in-flight reads; no beat for a pre-reset request SHALL appear after rst deasserts.
REQ-024 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro MEM_ALIGN_CHECK_EN SHALL control misalignment checking.
REQ-026 With MEM_ALIGN_CHECK_EN defined: for a read with memory_address[0]=1, memory_addr_err SHALL pulse with that read's valid beat. For a write with memory_address[0]=1, memory_addr_err SHALL pulse the following cycle, and the write SHALL still be performed.
REQ-027 Without MEM_ALIGN_CHECK_EN: memory_addr_err SHALL be tied 0 and no check logic SHALL exist.

Verification
REQ-028 Write 16'hBEEF to 16'h0040 in cycle 0; read 16'h0040 in cycle 1 -> valid=1 with data 16'hBEEF in cycle 5, and valid=0 in cycles 2-4 and 6.
REQ-029 Preload words 0x1000..0x100E with 0..7; issue 8 back-to-back reads -> 8 consecutive valid beats with data 0..7 in order, starting 4 cycles after the first read.
REQ-030 Assert read and write together to 16'h0020 with data 16'h1234 -> no valid beat; a read one cycle later returns 16'h1234.
REQ-031 Issue 3 reads, assert rst for 1 cycle two cycles later -> zero valid beats afterwards; array data preserved on subsequent reads.
REQ-032 With MEM_ALIGN_CHECK_EN, read 16'h0041 -> memory_addr_err=1 and valid=1 in the same cycle, with data equal to word 16'h0040. Without the macro, memory_addr_err stays 0.
